// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID pipeline register under stall, flush and redirect control.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = Jump | BranchTaken;
    // Jump outranks a simultaneous branch; targets are word-aligned on load.
    assign target   = Jump ? {JumpTarget[31:2], 2'b00} : {BranchTarget[31:2], 2'b00};
    assign Address  = {pc[31:2], 2'b00};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc               <= {RESET_PC[31:2], 2'b00};
            IFID_Instruction <= 32'd0;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
            FetchCount       <= 32'd0;
        end else if (redirect) begin
            pc               <= target;
            IFID_Instruction <= 32'd0;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else if (Stall && Flush) begin
            IFID_Instruction <= 32'd0;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else if (Stall) begin
            // Load-use hold: PC, IF/ID and the fetch counter all keep their values.
            pc <= pc;
        end else if (Flush) begin
            pc               <= pc_plus4;
            IFID_Instruction <= 32'd0;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else begin
            pc               <= pc_plus4;
            IFID_Instruction <= Instruction;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
            FetchCount       <= FetchCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized control
// traffic checked against a per-edge behavioural model of the fetch stage.
module tb_instruction_fetch_stage;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Address;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [64];

    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_p4;
    logic        m_valid;
    logic [31:0] m_cnt;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Instruction(Instruction),
        .Stall(Stall),
        .Flush(Flush),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .Address(Address),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid),
        .FetchCount(FetchCount)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // combinational instruction memory, 64 words, address aliases above 0x100
    always_comb Instruction = mem[Address[7:2]];

    task automatic model_reset();
        m_pc    = 32'd0;
        m_ins   = 32'd0;
        m_p4    = 32'd0;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
    endtask

    task automatic model_bubble();
        m_ins   = 32'd0;
        m_p4    = 32'd0;
        m_valid = 1'b0;
    endtask

    // One rising edge of the reference: decision from inputs seen at that edge.
    task automatic model_edge(input logic s, input logic f, input logic b,
                              input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic [31:0] next_seq;
        next_seq = m_pc + 32'd4;
        if (j || b) begin
            m_pc = (j ? jt : bt) & 32'hFFFF_FFFC;
            model_bubble();
        end else if (s) begin
            if (f) model_bubble();
        end else begin
            if (f) begin
                model_bubble();
            end else begin
                m_ins   = mem[m_pc[7:2]];
                m_p4    = next_seq;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            m_pc = next_seq;
        end
    endtask

    // driver: apply inputs, take one edge, update model, settle #1 past the edge
    task automatic cycle(input logic s, input logic f, input logic b,
                         input logic [31:0] bt, input logic j, input logic [31:0] jt);
        Stall        = s;
        Flush        = f;
        BranchTaken  = b;
        BranchTarget = bt;
        Jump         = j;
        JumpTarget   = jt;
        @(posedge Clk);
        model_edge(s, f, b, bt, j, jt);
        #1;
    endtask

    task automatic apply_reset();
        Rst = 1'b0;
        Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = 32'd0; JumpTarget = 32'd0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'd0, 32'd0, 32'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: addr=%h ins=%h p4=%h v=%b cnt=%0d expected all zero",
                     Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ins [3];
        exp_ins[0] = 32'h0000_4820; exp_ins[1] = 32'd0; exp_ins[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (IFID_Instruction !== exp_ins[i] || IFID_PCPlus4 !== 32'(4 * (i + 1)) || IFID_Valid !== 1'b1) begin
                n_err++;
                $display("FAIL seq_edge%0d: ins=%h p4=%h v=%b expected ins=%h p4=%h v=1",
                         i + 1, IFID_Instruction, IFID_PCPlus4, IFID_Valid, exp_ins[i], 32'(4 * (i + 1)));
            end
        end
        n_cmp++;
        if (Address !== 32'd12 || FetchCount !== 32'd3) begin
            n_err++;
            $display("FAIL seq_end: addr=%h cnt=%0d expected addr=0000000c cnt=3", Address, FetchCount);
        end
    endtask

    task automatic test_jump();
        cycle(0, 0, 0, 0, 1, 32'h14);
        n_cmp++;
        if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'd0 || IFID_PCPlus4 !== 32'd0 || Address !== 32'h14) begin
            n_err++;
            $display("FAIL jump_bubble: v=%b ins=%h p4=%h addr=%h expected bubble addr=00000014",
                     IFID_Valid, IFID_Instruction, IFID_PCPlus4, Address);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (IFID_Instruction !== 32'h2129_0006 || IFID_PCPlus4 !== 32'h18 || IFID_Valid !== 1'b1 || FetchCount !== 32'd4) begin
            n_err++;
            $display("FAIL jump_target: ins=%h p4=%h v=%b cnt=%0d expected 21290006 00000018 1 4",
                     IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_ins, hold_p4, hold_cnt;
        cycle(0, 0, 0, 0, 1, 32'h0C);
        cycle(0, 0, 0, 0, 0, 0);
        hold_ins = m_ins; hold_p4 = m_p4; hold_cnt = m_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            n_cmp++;
            if (Address !== 32'h10 || IFID_Instruction !== hold_ins || IFID_PCPlus4 !== hold_p4 ||
                IFID_Valid !== 1'b1 || FetchCount !== hold_cnt) begin
                n_err++;
                $display("FAIL stall_hold%0d: addr=%h ins=%h p4=%h v=%b cnt=%0d expected 00000010 %h %h 1 %0d",
                         i, Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount, hold_ins, hold_p4, hold_cnt);
            end
        end
        cycle(1, 1, 0, 0, 0, 0);
        n_cmp++;
        if (Address !== 32'h10 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'd0 || FetchCount !== hold_cnt) begin
            n_err++;
            $display("FAIL stall_flush: addr=%h v=%b ins=%h cnt=%0d expected 00000010 0 0 %0d",
                     Address, IFID_Valid, IFID_Instruction, FetchCount, hold_cnt);
        end
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (Address !== 32'h14 || IFID_Valid !== 1'b0 || FetchCount !== hold_cnt) begin
            n_err++;
            $display("FAIL flush_only: addr=%h v=%b cnt=%0d expected 00000014 0 %0d",
                     Address, IFID_Valid, FetchCount, hold_cnt);
        end
    endtask

    task automatic test_priority();
        cycle(1, 1, 1, 32'h80, 1, 32'h40);
        n_cmp++;
        if (Address !== 32'h40 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'd0) begin
            n_err++;
            $display("FAIL jump_over_all: addr=%h v=%b ins=%h expected 00000040 0 0", Address, IFID_Valid, IFID_Instruction);
        end
        cycle(0, 0, 1, 32'h17, 0, 0);
        n_cmp++;
        if (Address !== 32'h14 || IFID_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL branch_align: addr=%h v=%b expected 00000014 0", Address, IFID_Valid);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (IFID_PCPlus4 !== 32'd0 || Address !== 32'd0 || IFID_Valid !== 1'b1 || IFID_Instruction !== mem[63]) begin
            n_err++;
            $display("FAIL pc_wrap: p4=%h addr=%h v=%b ins=%h expected 00000000 00000000 1 %h",
                     IFID_PCPlus4, Address, IFID_Valid, IFID_Instruction, mem[63]);
        end
    endtask

    task automatic test_random();
        logic s, f, b, j;
        logic [31:0] bt, jt;
        for (int i = 0; i < 300; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 9) == 0);
            bt = 32'($urandom_range(0, 255));
            jt = 32'($urandom_range(0, 255));
            cycle(s, f, b, bt, j, jt);
            n_cmp++;
            if (Address !== m_pc || IFID_Instruction !== m_ins || IFID_PCPlus4 !== m_p4 ||
                IFID_Valid !== m_valid || FetchCount !== m_cnt) begin
                n_err++;
                $display("FAIL random_%0d: addr=%h ins=%h p4=%h v=%b cnt=%0d expected %h %h %h %b %0d",
                         i, Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount,
                         m_pc, m_ins, m_p4, m_valid, m_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (FetchCount !== 32'd5 || Address !== 32'd20) begin
            n_err++;
            $display("FAIL pre_reset: cnt=%0d addr=%h expected 5 00000014", FetchCount, Address);
        end
        Jump = 1'b1; JumpTarget = 32'h40;
        #3;
        Rst = 1'b0;
        #1;
        n_cmp++;
        if ({Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount} !== {32'd0, 32'd0, 32'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: addr=%h ins=%h p4=%h v=%b cnt=%0d expected all zero",
                     Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
        end
        model_reset();
        Jump = 1'b0; JumpTarget = 32'd0;
        @(negedge Clk);
        Rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (IFID_Instruction !== 32'h0000_4820 || IFID_PCPlus4 !== 32'd4 || IFID_Valid !== 1'b1 || FetchCount !== 32'd1) begin
            n_err++;
            $display("FAIL restart: ins=%h p4=%h v=%b cnt=%0d expected 00004820 00000004 1 1",
                     IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_4820;
        mem[1] = 32'd0;
        mem[2] = 32'd0;
        mem[5] = 32'h2129_0006;

        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_priority();
        test_wrap();
        test_random();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
